serial_subtractor_8_bits: RTL and testbench
===========================================

SERIAL_SUBTRACTOR_8_BITS -- requirements
Module: serial_subtractor_8_bits

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits, legal values 2 to 32.

Interface
REQ-002 CLK  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 START  input  1  request pulse; samples the operands.
REQ-005 BIN  input  1  borrow-in, sampled with START.
REQ-006 A  input  WIDTH  minuend, sampled with START.
REQ-007 B  input  WIDTH  subtrahend, sampled with START.
REQ-008 D  output  WIDTH  registered difference, D = A - B - BIN modulo 2^WIDTH.
REQ-009 BOUT  output  1  registered borrow-out: 1 when A < B + BIN, unsigned.
REQ-010 V  output  1  registered signed overflow: the two's-complement result does not fit in WIDTH bits.
REQ-011 BUSY  output  1  high while a subtraction is in progress.
REQ-012 DONE  output  1  one-cycle pulse; D, BOUT and V are valid for the result just finished.

Function
REQ-013 The FSM SHALL have three states:
- IDLE: waiting for a request.
- RUN: processing bits.
- FINISH: result valid.
REQ-014 IDLE -> RUN SHALL occur when START=1 at an edge; at that edge A, B and BIN are latched into internal shift registers and the bit counter is cleared to 0.
REQ-015 In RUN, one bit SHALL be processed per edge, LSB first:
- difference bit d = a XOR b XOR br.
- next borrow br = (~a & b) | (~(a XOR b) & br).
- br starts at the latched BIN.
REQ-016 RUN -> FINISH SHALL occur at the edge that processes bit WIDTH-1.
- At that edge D, BOUT and V are loaded.
- BOUT is the final borrow.
- V is the borrow into the MSB XOR the borrow out of the MSB.
REQ-017 FINISH -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 Latency: for START sampled at edge k, DONE SHALL be high in exactly the cycle between edges k+WIDTH and k+WIDTH+1, and low in every other cycle.
REQ-019 BUSY SHALL be 1 exactly while the state is RUN or FINISH, and 0 in IDLE.
REQ-020 START in RUN or FINISH SHALL be ignored: the operands are not re-latched, the counter is not disturbed and no request is queued.
REQ-021 START held high continuously SHALL start a new subtraction on the first edge back in IDLE, giving back-to-back results every WIDTH+2 cycles.
REQ-022 D, BOUT and V SHALL change only at the RUN -> FINISH edge or on reset; partial results are never visible on D, and outputs hold between operations.
REQ-023 A, B and BIN changing after the START edge SHALL NOT affect the result in progress.
REQ-024 Wrap-around: D SHALL be the result modulo 2^WIDTH with no saturation; underflow is reported only through BOUT.

Reset
REQ-025 RST=1 at an edge SHALL set:
- state = IDLE, counter = 0.
- D = 0, BOUT = 0, V = 0, BUSY = 0, DONE = 0.
- all internal shift registers = 0.
REQ-026 RST SHALL have priority over START at the same edge.
REQ-027 RST asserted mid-operation SHALL abort the operation: no DONE pulse occurs for it, and the previous D is cleared.
REQ-028 The first START after RST deasserts SHALL operate normally.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover these scenarios:
- A=0xFF, B=0x00, BIN=0 -> D=0xFF, BOUT=0, V=0; DONE high only in cycle 8 after the START edge; BUSY high for 9 cycles.
- A=0xAE, B=0x26, BIN=0 -> D=0x88, BOUT=0, V=0.
- A=0x00, B=0x01, BIN=0 -> D=0xFF, BOUT=1, V=0; then A=0x80, B=0x01 -> D=0x7F, BOUT=0, V=1.
- A=0x10, B=0x10, BIN=1 -> D=0xFF, BOUT=1, V=0; START pulsed with A=0x55 at edge k+3 is ignored and the result is still 0xFF; A and B changed mid-run are also ignored.
- RST pulsed at edge k+4 of a run with A=0x40, B=0x01 -> all outputs 0 the next cycle and no DONE pulse; a following START with A=0x03, B=0x02 -> D=0x01, BOUT=0.
- START held high for 30 cycles with constant A=0x05, B=0x03 -> DONE pulses every 10 cycles, each with D=0x02, BOUT=0.

Source files
------------

// File: rtl/serial_subtractor_8_bits.sv
// Bit-serial subtractor: latches A, B and BIN on START, then resolves one
// difference bit per clock (LSB first) and publishes D, BOUT and V together.
module serial_subtractor_8_bits #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             BIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             V,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [CNT_W-1:0] count;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] d_next;

  // One full-subtractor slice acting on the current LSBs of the operand shifters.
  assign a_bit   = a_sr[0];
  assign b_bit   = b_sr[0];
  assign d_bit   = a_bit ^ b_bit ^ br;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign d_next  = {d_bit, d_sr[WIDTH-1:1]};

  // Partial differences stay in d_sr; D only changes when the final bit lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      count <= '0;
      br    <= 1'b0;
      D     <= '0;
      BOUT  <= 1'b0;
      V     <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= BIN;
            d_sr  <= '0;
            count <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          d_sr  <= d_next;
          br    <= br_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            // br is the borrow into the MSB, br_next the borrow out of it.
            D     <= d_next;
            BOUT  <= br_next;
            V     <= br ^ br_next;
            DONE  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8_bits.sv
// Self-checking bench: directed scenarios plus random operands compared
// against an arithmetic reference of A - B - BIN.
module tb_serial_subtractor_8_bits;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             START = 1'b0;
  logic             BIN = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             V;
  logic             BUSY;
  logic             DONE;

  int totalChecks = 0;
  int badChecks = 0;
  logic [WIDTH-1:0] prevD = '0;

  serial_subtractor_8_bits #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BIN(BIN), .A(A), .B(B),
    .D(D), .BOUT(BOUT), .V(V), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference computed from plain integer arithmetic on the operands.
  function automatic void refSub(input int a, input int b, input int bin,
                                 output logic [WIDTH-1:0] d, output logic bo,
                                 output logic v);
    int diff;
    int sa;
    int sb;
    int sd;
    diff = a - b - bin;
    d    = diff[WIDTH-1:0];
    bo   = (diff < 0);
    sa   = (a >= 128) ? a - 256 : a;
    sb   = (b >= 128) ? b - 256 : b;
    sd   = sa - sb - bin;
    v    = (sd < -128) || (sd > 127);
  endfunction

  // One operation; disturb pulses START and scrambles operands mid-run.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin, input bit disturb);
    logic [WIDTH-1:0] expD;
    logic expB;
    logic expV;
    refSub(int'(a), int'(b), int'(bin), expD, expB, expV);
    @(negedge CLK);
    A = a; B = b; BIN = bin; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int i = 0; i <= WIDTH + 1; i++) begin
      @(negedge CLK);
      checkOutput("busy", 32'(BUSY), 32'(i <= WIDTH));
      checkOutput("done", 32'(DONE), 32'(i == WIDTH));
      if (i < WIDTH) begin
        checkOutput("hold_d", 32'(D), 32'(prevD));
      end else begin
        checkOutput("d", 32'(D), 32'(expD));
        checkOutput("bout", 32'(BOUT), 32'(expB));
        checkOutput("v", 32'(V), 32'(expV));
      end
      if (disturb && i == 2) begin
        START = 1'b1; A = 8'h55; B = 8'($urandom); BIN = ~bin;
      end
      if (disturb && i == 3) START = 1'b0;
    end
    prevD = expD;
  endtask

  // Reset lands on edge k+4 of a running subtraction.
  task automatic abortRun(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge CLK);
    A = a; B = b; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int i = 0; i <= WIDTH + 2; i++) begin
      @(negedge CLK);
      checkOutput("abort_done", 32'(DONE), 32'd0);
      checkOutput("abort_busy", 32'(BUSY), 32'(i < 4));
      if (i == 4) begin
        checkOutput("abort_d", 32'(D), 32'd0);
        checkOutput("abort_bout", 32'(BOUT), 32'd0);
        checkOutput("abort_v", 32'(V), 32'd0);
      end
      if (i == 3) RST = 1'b1;
      if (i == 4) RST = 1'b0;
    end
    prevD = '0;
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_d", 32'(D), 32'd0);
    checkOutput("rst_bout", 32'(BOUT), 32'd0);
    checkOutput("rst_v", 32'(V), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_done", 32'(DONE), 32'd0);

    // Reset outranks START on the same edge.
    START = 1'b1; A = 8'h12; B = 8'h34;
    @(negedge CLK);
    checkOutput("rst_prio_busy", 32'(BUSY), 32'd0);
    RST = 1'b0; START = 1'b0;

    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'hAE, 8'h26, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h10, 1'b1, 1'b1);
    applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);

    abortRun(8'h40, 8'h01);
    applyStimulus(8'h03, 8'h02, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    // START held high: a fresh result every WIDTH+2 cycles.
    @(negedge CLK);
    A = 8'h05; B = 8'h03; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      checkOutput("held_done", 32'(DONE), 32'((j % (WIDTH + 2)) == WIDTH));
      if ((j % (WIDTH + 2)) == WIDTH) begin
        checkOutput("held_d", 32'(D), 32'h02);
        checkOutput("held_bout", 32'(BOUT), 32'd0);
      end
      if (j == 29) START = 1'b0;
    end
    repeat (2) @(negedge CLK);
    checkOutput("final_busy", 32'(BUSY), 32'd0);
    checkOutput("final_d", 32'(D), 32'h02);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
